// File: rtl/wb_stage_if.sv
// wb_stage_if: MEM-stage retire bus, data-memory load return and regfile
// write port of the write-back stage, bundled for the stage boundary.
interface wb_stage_if;
  logic        mem_valid;
  logic        mem_we;
  logic [4:0]  mem_waddr;
  logic [31:0] mem_wdata;
  logic        mem_load;
  logic [2:0]  mem_ld_type;
  logic [1:0]  mem_addr_lo;
  logic        flush;
  logic        dmem_rvalid;
  logic [31:0] dmem_rdata;
  logic        we;
  logic [4:0]  waddr;
  logic [31:0] wdata;
  logic        stall_req;
  logic        busy;

  modport master (
    output mem_valid, mem_we, mem_waddr, mem_wdata, mem_load, mem_ld_type,
           mem_addr_lo, flush, dmem_rvalid, dmem_rdata,
    input  we, waddr, wdata, stall_req, busy
  );

  modport slave (
    input  mem_valid, mem_we, mem_waddr, mem_wdata, mem_load, mem_ld_type,
           mem_addr_lo, flush, dmem_rvalid, dmem_rdata,
    output we, waddr, wdata, stall_req, busy
  );
endinterface

// File: rtl/wb_stage.sv
// wb_stage: write-back stage of the 5-stage MIPS pipeline. Registers retiring
// results onto the regfile write port and parks in WAIT for variable-latency
// load returns, holding MEM upstream via stall_req meanwhile.
// Optional feature macro: WB_SUBWORD_LOAD_EN enables lb/lbu/lh/lhu byte/half
// extraction; without it every load writes the full returned word.
module wb_stage (
  input  logic       clk,
  input  logic       rst,
  wb_stage_if.slave  bus
);

  typedef enum logic {IDLE, WAIT} state_t;

  state_t      state_q, state_d;

  // Latched load context (captured when a load is accepted)
  logic        ld_we_p0;
  logic [4:0]  ld_waddr_p0;
  logic [2:0]  ld_type_p0;
  logic [1:0]  ld_addr_lo_p0;

  // Registered regfile write port
  logic        we_p1;
  logic [4:0]  waddr_p1;
  logic [31:0] wdata_p1;

  logic        we_d;
  logic [4:0]  waddr_d;
  logic [31:0] wdata_d;
  logic        latch_ld;
  logic        stall;
  logic [31:0] load_data;

`ifdef WB_SUBWORD_LOAD_EN
  // Align and extend the returned word; ld_type 0 and 5-7 are plain lw.
  // A halfword uses addr_lo[1] only; misalignment is not trapped here.
  function automatic logic [31:0] extract(input logic [2:0]  ld_type,
                                          input logic [1:0]  lo,
                                          input logic [31:0] d);
    logic signed [7:0]  b;
    logic signed [15:0] h;
    case (lo)
      2'd0:    b = d[7:0];
      2'd1:    b = d[15:8];
      2'd2:    b = d[23:16];
      default: b = d[31:24];
    endcase
    h = lo[1] ? d[31:16] : d[15:0];
    case (ld_type)
      3'd1:    return {{24{b[7]}}, b};
      3'd2:    return {24'd0, b};
      3'd3:    return {{16{h[15]}}, h};
      3'd4:    return {16'd0, h};
      default: return d;
    endcase
  endfunction

  assign load_data = extract(ld_type_p0, ld_addr_lo_p0, bus.dmem_rdata);
`else
  logic unused_ld_ctx;
  assign unused_ld_ctx = ^{ld_type_p0, ld_addr_lo_p0};
  assign load_data     = bus.dmem_rdata;
`endif

  // Next-state, next write-port values and load-context capture
  always_comb begin
    state_d  = state_q;
    we_d     = 1'b0;
    waddr_d  = waddr_p1;
    wdata_d  = wdata_p1;
    latch_ld = 1'b0;
    stall    = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.mem_valid && !bus.flush) begin
          if (bus.mem_load) begin
            latch_ld = 1'b1;
            state_d  = WAIT;
          end else begin
            we_d    = bus.mem_we && (bus.mem_waddr != 5'd0);
            waddr_d = bus.mem_waddr;
            wdata_d = bus.mem_wdata;
          end
        end
      end
      WAIT: begin
        // A load in WAIT is committed: flush and mem_* are not looked at
        stall = !bus.dmem_rvalid;
        if (bus.dmem_rvalid) begin
          we_d    = ld_we_p0 && (ld_waddr_p0 != 5'd0);
          waddr_d = ld_waddr_p0;
          wdata_d = load_data;
          state_d = IDLE;
        end
      end
    endcase
  end

  // State register; reset abandons any outstanding load
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Load context capture on acceptance
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ld_we_p0      <= 1'b0;
      ld_waddr_p0   <= 5'd0;
      ld_type_p0    <= 3'd0;
      ld_addr_lo_p0 <= 2'd0;
    end else if (latch_ld) begin
      ld_we_p0      <= bus.mem_we;
      ld_waddr_p0   <= bus.mem_waddr;
      ld_type_p0    <= bus.mem_ld_type;
      ld_addr_lo_p0 <= bus.mem_addr_lo;
    end
  end

  // Regfile write-port register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      we_p1    <= 1'b0;
      waddr_p1 <= 5'd0;
      wdata_p1 <= 32'd0;
    end else begin
      we_p1    <= we_d;
      waddr_p1 <= waddr_d;
      wdata_p1 <= wdata_d;
    end
  end

  assign bus.we        = we_p1;
  assign bus.waddr     = waddr_p1;
  assign bus.wdata     = wdata_p1;
  assign bus.stall_req = stall;
  assign bus.busy      = (state_q == WAIT);

endmodule

// File: tb/tb_wb_stage.sv
// tb_wb_stage: self-checking bench for wb_stage with directed and randomized
// retire/load traffic against a transaction-level reference model.
module tb_wb_stage;

  logic clk = 1'b0;
  logic rst;

  wb_stage_if bus();

  wb_stage dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Expected write port (waddr/wdata hold when nothing is written)
  logic        exp_we;
  logic [4:0]  exp_waddr;
  logic [31:0] exp_wdata;

  // Reference load extraction from the byte-lane / halfword rules
  function automatic logic [31:0] model_load(input int t, input int lo, input logic [31:0] d);
    int tt;
    logic [31:0] byt, half;
    tt = t;
`ifndef WB_SUBWORD_LOAD_EN
    tt = 0;
`endif
    byt  = (d >> (8 * lo)) & 32'h0000_00FF;
    half = (d >> (16 * (lo / 2))) & 32'h0000_FFFF;
    case (tt)
      1:       return (byt >= 32'd128) ? byt + 32'hFFFF_FF00 : byt;
      2:       return byt;
      3:       return (half >= 32'd32768) ? half + 32'hFFFF_0000 : half;
      4:       return half;
      default: return d;
    endcase
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs;
    bus.mem_valid   = 1'b0;
    bus.mem_we      = 1'b0;
    bus.mem_waddr   = 5'd0;
    bus.mem_wdata   = 32'd0;
    bus.mem_load    = 1'b0;
    bus.mem_ld_type = 3'd0;
    bus.mem_addr_lo = 2'd0;
    bus.flush       = 1'b0;
    bus.dmem_rvalid = 1'b0;
    bus.dmem_rdata  = 32'd0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    idle_inputs();
    tick();
    tick();
    rst = 1'b0;
    checks++;
    if ({bus.we, bus.waddr, bus.wdata, bus.stall_req, bus.busy} !== 40'd0) begin
      failures++;
      $display("FAIL reset_init: we/waddr/wdata/stall/busy=%b/%0d/%h/%b/%b required all zero",
               bus.we, bus.waddr, bus.wdata, bus.stall_req, bus.busy);
    end
    // Put non-zero values on the write port, then reset asynchronously mid-cycle
    bus.mem_valid = 1'b1; bus.mem_we = 1'b1; bus.mem_waddr = 5'd9; bus.mem_wdata = 32'hDEAD_BEEF;
    tick();
    idle_inputs();
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({bus.we, bus.waddr, bus.wdata, bus.stall_req, bus.busy} !== 40'd0) begin
      failures++;
      $display("FAIL reset_async: we/waddr/wdata/stall/busy=%b/%0d/%h/%b/%b required all zero",
               bus.we, bus.waddr, bus.wdata, bus.stall_req, bus.busy);
    end
    @(negedge clk) rst = 1'b0;
    tick();
    exp_we = 1'b0; exp_waddr = 5'd0; exp_wdata = 32'd0;
  endtask

  // Consecutive non-loads, one per cycle, then an idle cycle
  task automatic test_nonload;
    logic [4:0]  ad [4];
    logic [31:0] dt [4];
    logic        wr [4];
    ad = '{5'd5, 5'd0, 5'd7, 5'd31};
    dt = '{32'h1234_5678, 32'h1234_5678, 32'hA5A5_A5A5, $urandom};
    wr = '{1'b1, 1'b1, 1'b0, 1'b1};
    for (int i = 0; i < 4; i++) begin
      bus.mem_valid = 1'b1; bus.mem_load = 1'b0;
      bus.mem_we = wr[i]; bus.mem_waddr = ad[i]; bus.mem_wdata = dt[i];
      tick();
      exp_we = wr[i] && (ad[i] != 5'd0); exp_waddr = ad[i]; exp_wdata = dt[i];
      checks++;
      if ({bus.we, bus.waddr, bus.wdata} !== {exp_we, exp_waddr, exp_wdata}) begin
        failures++;
        $display("FAIL nonload_%0d: we/waddr/wdata=%b/%0d/%h required %b/%0d/%h",
                 i, bus.we, bus.waddr, bus.wdata, exp_we, exp_waddr, exp_wdata);
      end
    end
    idle_inputs();
    tick();
    exp_we = 1'b0;
    checks++;
    if ({bus.we, bus.waddr, bus.wdata} !== {exp_we, exp_waddr, exp_wdata}) begin
      failures++;
      $display("FAIL nonload_idle_hold: we/waddr/wdata=%b/%0d/%h required %b/%0d/%h",
               bus.we, bus.waddr, bus.wdata, exp_we, exp_waddr, exp_wdata);
    end
  endtask

  // Directed loads: type, addr_lo, data, WAIT cycles, flush while waiting
  task automatic test_loads;
    int          ty [7];
    int          lo [7];
    logic [31:0] dt [7];
    int          lat [7];
    logic        fw [7];
    ty  = '{1, 2, 3, 4, 3, 0, 6};
    lo  = '{2, 2, 2, 2, 3, 1, 3};
    dt  = '{32'h0080_0000, 32'h0080_0000, 32'h8001_FFFF, 32'h8001_FFFF,
            32'h8001_FFFF, 32'hCAFE_BABE, 32'h1357_9BDF};
    lat = '{3, 3, 1, 1, 2, 2, 4};
    fw  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    for (int i = 0; i < 7; i++) begin
      bus.mem_valid = 1'b1; bus.mem_load = 1'b1; bus.mem_we = 1'b1;
      bus.mem_waddr = 5'(10 + i); bus.mem_wdata = $urandom;
      bus.mem_ld_type = 3'(ty[i]); bus.mem_addr_lo = 2'(lo[i]);
      tick();
      checks++;
      if (bus.we !== 1'b0 || bus.busy !== 1'b1) begin
        failures++;
        $display("FAIL load_accept_%0d: we/busy=%b/%b required 0/1", i, bus.we, bus.busy);
      end
      for (int c = 0; c < lat[i]; c++) begin
        bus.flush       = fw[i];
        bus.dmem_rvalid = (c == lat[i] - 1);
        bus.dmem_rdata  = (c == lat[i] - 1) ? dt[i] : $urandom;
        #1;
        checks++;
        if (bus.stall_req !== !bus.dmem_rvalid) begin
          failures++;
          $display("FAIL load_stall_%0d_c%0d: stall_req=%b required %b",
                   i, c, bus.stall_req, !bus.dmem_rvalid);
        end
        tick();
        if (c < lat[i] - 1) begin
          checks++;
          if (bus.we !== 1'b0 || bus.busy !== 1'b1) begin
            failures++;
            $display("FAIL load_wait_%0d_c%0d: we/busy=%b/%b required 0/1", i, c, bus.we, bus.busy);
          end
        end
      end
      exp_we = 1'b1; exp_waddr = 5'(10 + i); exp_wdata = model_load(ty[i], lo[i], dt[i]);
      checks++;
      if ({bus.we, bus.waddr, bus.wdata, bus.busy} !== {exp_we, exp_waddr, exp_wdata, 1'b0}) begin
        failures++;
        $display("FAIL load_write_%0d: we/waddr/wdata/busy=%b/%0d/%h/%b required %b/%0d/%h/0",
                 i, bus.we, bus.waddr, bus.wdata, bus.busy, exp_we, exp_waddr, exp_wdata);
      end
      idle_inputs();
      tick();
      exp_we = 1'b0;
      checks++;
      if (bus.we !== 1'b0 || bus.busy !== 1'b0) begin
        failures++;
        $display("FAIL load_after_%0d: we/busy=%b/%b required 0/0", i, bus.we, bus.busy);
      end
    end
  endtask

  task automatic test_flush;
    bus.mem_valid = 1'b1; bus.mem_we = 1'b1; bus.mem_waddr = 5'd3;
    bus.mem_wdata = 32'h0BAD_F00D; bus.flush = 1'b1;
    tick();
    checks++;
    if ({bus.we, bus.waddr, bus.wdata} !== {1'b0, exp_waddr, exp_wdata}) begin
      failures++;
      $display("FAIL flush_nonload: we/waddr/wdata=%b/%0d/%h required 0/%0d/%h",
               bus.we, bus.waddr, bus.wdata, exp_waddr, exp_wdata);
    end
    bus.mem_load = 1'b1;
    tick();
    checks++;
    if (bus.busy !== 1'b0 || bus.we !== 1'b0) begin
      failures++;
      $display("FAIL flush_load: busy/we=%b/%b required 0/0", bus.busy, bus.we);
    end
    idle_inputs();
  endtask

  task automatic test_spurious;
    bus.dmem_rvalid = 1'b1; bus.dmem_rdata = 32'hFFFF_FFFF;
    #1;
    checks++;
    if (bus.stall_req !== 1'b0) begin
      failures++;
      $display("FAIL spurious_stall: stall_req=%b required 0", bus.stall_req);
    end
    tick();
    checks++;
    if ({bus.we, bus.waddr, bus.wdata, bus.busy} !== {1'b0, exp_waddr, exp_wdata, 1'b0}) begin
      failures++;
      $display("FAIL spurious_rvalid: we/waddr/wdata/busy=%b/%0d/%h/%b required 0/%0d/%h/0",
               bus.we, bus.waddr, bus.wdata, bus.busy, exp_waddr, exp_wdata);
    end
    idle_inputs();
  endtask

  task automatic test_rst_in_wait;
    bus.mem_valid = 1'b1; bus.mem_load = 1'b1; bus.mem_we = 1'b1; bus.mem_waddr = 5'd12;
    tick();
    checks++;
    if (bus.busy !== 1'b1) begin
      failures++;
      $display("FAIL rstwait_accept: busy=%b required 1", bus.busy);
    end
    idle_inputs();
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({bus.we, bus.waddr, bus.wdata, bus.stall_req, bus.busy} !== 40'd0) begin
      failures++;
      $display("FAIL rstwait_reset: we/waddr/wdata/stall/busy=%b/%0d/%h/%b/%b required all zero",
               bus.we, bus.waddr, bus.wdata, bus.stall_req, bus.busy);
    end
    @(negedge clk) rst = 1'b0;
    tick();
    bus.dmem_rvalid = 1'b1; bus.dmem_rdata = 32'h7777_7777;
    tick();
    exp_we = 1'b0; exp_waddr = 5'd0; exp_wdata = 32'd0;
    checks++;
    if ({bus.we, bus.waddr, bus.wdata, bus.busy} !== 39'd0) begin
      failures++;
      $display("FAIL rstwait_late_rvalid: we/waddr/wdata/busy=%b/%0d/%h/%b required all zero",
               bus.we, bus.waddr, bus.wdata, bus.busy);
    end
    idle_inputs();
  endtask

  // Randomized mix of non-loads, loads, flushed slots and idle/spurious cycles
  task automatic test_random;
    for (int n = 0; n < 300; n++) begin
      int kind;
      kind = int'($urandom_range(0, 3));
      idle_inputs();
      bus.mem_we    = 1'($urandom);
      bus.mem_waddr = 5'($urandom);
      bus.mem_wdata = $urandom;
      if (kind == 1) begin
        int lat, t, l;
        logic [31:0] d;
        lat = int'($urandom_range(1, 4));
        t   = int'($urandom_range(0, 7));
        l   = int'($urandom_range(0, 3));
        d   = $urandom;
        bus.mem_valid = 1'b1; bus.mem_load = 1'b1;
        bus.mem_ld_type = 3'(t); bus.mem_addr_lo = 2'(l);
        exp_waddr = bus.mem_waddr;
        exp_we    = bus.mem_we && (bus.mem_waddr != 5'd0);
        exp_wdata = model_load(t, l, d);
        tick();
        for (int c = 0; c < lat; c++) begin
          bus.flush       = 1'($urandom);
          bus.dmem_rvalid = (c == lat - 1);
          bus.dmem_rdata  = (c == lat - 1) ? d : $urandom;
          #1;
          checks++;
          if (bus.stall_req !== !bus.dmem_rvalid || bus.busy !== 1'b1) begin
            failures++;
            $display("FAIL rnd_wait_%0d_c%0d: stall/busy=%b/%b required %b/1",
                     n, c, bus.stall_req, bus.busy, !bus.dmem_rvalid);
          end
          tick();
        end
      end else begin
        bus.mem_valid   = (kind != 2);
        bus.flush       = (kind == 3);
        bus.dmem_rvalid = (kind == 2) ? 1'($urandom) : 1'b0;
        bus.dmem_rdata  = $urandom;
        if (kind == 0) begin
          exp_we    = bus.mem_we && (bus.mem_waddr != 5'd0);
          exp_waddr = bus.mem_waddr;
          exp_wdata = bus.mem_wdata;
        end else begin
          exp_we = 1'b0;
        end
        tick();
      end
      checks++;
      if ({bus.we, bus.waddr, bus.wdata, bus.busy} !== {exp_we, exp_waddr, exp_wdata, 1'b0}) begin
        failures++;
        $display("FAIL rnd_%0d_kind%0d: we/waddr/wdata/busy=%b/%0d/%h/%b required %b/%0d/%h/0",
                 n, kind, bus.we, bus.waddr, bus.wdata, bus.busy, exp_we, exp_waddr, exp_wdata);
      end
    end
    idle_inputs();
  endtask

  initial begin
    rst = 1'b0;
    idle_inputs();
    exp_we = 1'b0; exp_waddr = 5'd0; exp_wdata = 32'd0;
    #2;
    test_reset();
    test_nonload();
    test_loads();
    test_flush();
    test_spurious();
    test_rst_in_wait();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Absolute bound so the run always ends
  initial begin
    #200000;
    $display("FAIL timeout: simulation time limit reached, required completion");
    $fatal(1, "timeout");
  end

endmodule
